// File: rtl/vga_sprite_composer.sv
// Pixel-colour stage: composites one ROM-fetched sprite over a solid background with 2-cycle latency.
// Define SPRITE_SCALE2X_EN to draw the sprite at 2x in each axis.
module vga_sprite_composer #(
    parameter int          SPR_W           = 32,
    parameter int          SPR_H           = 32,
    parameter int          ADDR_W          = 10,
    parameter logic [23:0] TRANSPARENT_KEY = 24'hFF00FF
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        x_pos,
    input  logic [9:0]        y_pos,
    input  logic              wr_en,
    input  logic [1:0]        wr_addr,
    input  logic [23:0]       wr_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start
);

    function automatic logic [23:0] pick_rgb(input logic vld, input logic hit,
                                             input logic [23:0] tex, input logic [23:0] bg);
        if (!vld)
            return 24'h000000;
        else if (hit && (tex != TRANSPARENT_KEY))
            return tex;
        else
            return bg;
    endfunction

    logic [9:0]  shd_x_q, shd_y_q, act_x_q, act_y_q;
    logic        shd_en_q, act_en_q;
    logic [23:0] shd_bg_q, act_bg_q;

    logic [10:0]       dx_p0, dy_p0;
    logic              vld_p0, hit_p0, commit_p0;
    logic [ADDR_W-1:0] addr_p0;

    logic        vld_p1_q, hit_p1_q, frame_start_q;
    logic [23:0] rgb_d, rgb_q;

    // Stage p0: sprite hit test and ROM address, straight from the raw counters
    assign commit_p0 = (x_pos == 10'd0) && (y_pos == 10'd480);
    assign vld_p0    = (x_pos < 10'd640) && (y_pos < 10'd480);
    assign dx_p0     = {1'b0, x_pos} - {1'b0, act_x_q};
    assign dy_p0     = {1'b0, y_pos} - {1'b0, act_y_q};

`ifdef SPRITE_SCALE2X_EN
    assign hit_p0  = act_en_q && vld_p0
                  && ({1'b0, x_pos} >= {1'b0, act_x_q}) && (dx_p0 < 11'(2 * SPR_W))
                  && ({1'b0, y_pos} >= {1'b0, act_y_q}) && (dy_p0 < 11'(2 * SPR_H));
    assign addr_p0 = ADDR_W'(dy_p0 >> 1) * ADDR_W'(SPR_W) + ADDR_W'(dx_p0 >> 1);
`else
    assign hit_p0  = act_en_q && vld_p0
                  && ({1'b0, x_pos} >= {1'b0, act_x_q}) && (dx_p0 < 11'(SPR_W))
                  && ({1'b0, y_pos} >= {1'b0, act_y_q}) && (dy_p0 < 11'(SPR_H));
    assign addr_p0 = ADDR_W'(dy_p0) * ADDR_W'(SPR_W) + ADDR_W'(dx_p0);
`endif

    assign rom_addr = hit_p0 ? addr_p0 : '0;

    // Stage p2: ROM word is valid now; background comes from the active register
    always_comb begin
        rgb_d = pick_rgb(vld_p1_q, hit_p1_q, rom_data, act_bg_q);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            shd_x_q       <= '0;
            shd_y_q       <= '0;
            shd_en_q      <= 1'b0;
            shd_bg_q      <= '0;
            act_x_q       <= '0;
            act_y_q       <= '0;
            act_en_q      <= 1'b0;
            act_bg_q      <= '0;
            vld_p1_q      <= 1'b0;
            hit_p1_q      <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    2'd0:    shd_x_q  <= wr_data[9:0];
                    2'd1:    shd_y_q  <= wr_data[9:0];
                    2'd2:    shd_en_q <= wr_data[0];
                    default: shd_bg_q <= wr_data;
                endcase
            end
            // Commit reads the shadow before this edge, so a same-cycle write waits a frame
            if (commit_p0) begin
                act_x_q  <= shd_x_q;
                act_y_q  <= shd_y_q;
                act_en_q <= shd_en_q;
                act_bg_q <= shd_bg_q;
            end
            vld_p1_q      <= vld_p0;
            hit_p1_q      <= hit_p0;
            rgb_q         <= rgb_d;
            frame_start_q <= commit_p0;
        end
    end

    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sprite_composer.sv
// Bench for vga_sprite_composer: pixel-level reference model plus hand-computed spot values.
module tb_vga_sprite_composer;

    localparam int          SPR_W  = 32;
    localparam int          SPR_H  = 32;
    localparam int          ADDR_W = 10;
    localparam logic [23:0] KEY    = 24'hFF00FF;
`ifdef SPRITE_SCALE2X_EN
    localparam int SC = 2;
`else
    localparam int SC = 1;
`endif

    logic              vga_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [9:0]        x_pos   = 10'd799;
    logic [9:0]        y_pos   = 10'd524;
    logic              wr_en   = 1'b0;
    logic [1:0]        wr_addr = 2'd0;
    logic [23:0]       wr_data = 24'd0;
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_data = 24'd0;
    logic [7:0]        vga_r, vga_g, vga_b;
    logic              frame_start;
    logic [23:0]       rgb;

    vga_sprite_composer #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .TRANSPARENT_KEY(KEY)) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .x_pos(x_pos), .y_pos(y_pos),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
    );

    always #20 vga_clk = ~vga_clk;
    assign rgb = {vga_r, vga_g, vga_b};

    function automatic logic [23:0] rom_fn(input logic [9:0] a);
        return (a == 10'd5) ? KEY : (24'hA00000 | 24'(a));
    endfunction

    always @(posedge vga_clk) rom_data <= rom_fn(rom_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    // Reference model state: shadow/active registers and expectation history
    int          s_sx = 0, s_sy = 0, m_sx = 0, m_sy = 0;
    bit          s_en = 0, m_en = 0;
    logic [23:0] s_bg = 0, m_bg = 0;
    bit          pend_c = 0, pend_we = 0;
    int          pend_a = 0;
    logic [23:0] pend_d = 0;
    logic [23:0] p0 = 0, p1 = 0, exp_rgb = 0;
    logic [9:0]  exp_addr = 0;
    bit          exp_fs = 0;
    bit          chk_en = 0;

    function automatic void model(input int x, input int y, output logic [9:0] ea, output logic [23:0] pv);
        int ix, iy, a;
        bit act, ins;
        ix  = x - m_sx;
        iy  = y - m_sy;
        act = (x < 640) && (y < 480);
        ins = m_en && act && (ix >= 0) && (ix < SC * SPR_W) && (iy >= 0) && (iy < SC * SPR_H);
        a   = ins ? (iy / SC) * SPR_W + (ix / SC) : 0;
        ea  = 10'(a);
        if (!act)                          pv = 24'h0;
        else if (ins && rom_fn(ea) != KEY) pv = rom_fn(ea);
        else                               pv = m_bg;
    endfunction

    task automatic step(input int x, input int y, input bit we = 0, input int a = 0, input logic [23:0] d = 0);
        logic [9:0]  ea;
        logic [23:0] pv;
        @(posedge vga_clk);
        if (pend_c) begin
            m_sx = s_sx; m_sy = s_sy; m_en = s_en; m_bg = s_bg;
        end
        if (pend_we) begin
            case (pend_a)
                0:       s_sx = int'(pend_d[9:0]);
                1:       s_sy = int'(pend_d[9:0]);
                2:       s_en = pend_d[0];
                default: s_bg = pend_d;
            endcase
        end
        #1;
        x_pos = 10'(x); y_pos = 10'(y);
        wr_en = we; wr_addr = 2'(a); wr_data = d;
        model(x, y, ea, pv);
        exp_addr = ea;
        exp_fs   = pend_c;
        exp_rgb  = p1;
        p1 = p0;
        p0 = pv;
        pend_c = (x == 0) && (y == 480);
        pend_we = we; pend_a = a; pend_d = d;
    endtask

    always @(negedge vga_clk) begin
        if (chk_en && reset_n) begin
            chk("model_rom_addr", 32'(rom_addr), 32'(exp_addr));
            chk("model_rgb", 32'(rgb), 32'(exp_rgb));
            chk("model_frame_start", 32'(frame_start), 32'(exp_fs));
        end
    end

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                step(x, y);
    endtask

    task automatic wr(input int a, input logic [23:0] d);
        step(640, 490, 1, a, d);
    endtask

    task automatic commit(input bit we = 0, input int a = 0, input logic [23:0] d = 0);
        step(0, 480, we, a, d);
        step(1, 480);
        @(negedge vga_clk);
        chk("fs_pulse", 32'(frame_start), 32'd1);
        step(2, 480);
        @(negedge vga_clk);
        chk("fs_single", 32'(frame_start), 32'd0);
    endtask

    task automatic lit(input string nm, input int x, input int y, input logic [9:0] ea, input logic [23:0] er);
        step(x, y);
        @(negedge vga_clk);
        chk({nm, "_addr"}, 32'(rom_addr), 32'(ea));
        step(x + 1, y);
        step(x + 2, y);
        @(negedge vga_clk);
        chk({nm, "_rgb"}, 32'(rgb), 32'(er));
    endtask

    task automatic mid_reset();
        @(posedge vga_clk);
        #1;
        reset_n = 1'b0;
        chk_en  = 0;
        wr_en   = 1'b0;
        #2;
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        s_sx = 0; s_sy = 0; s_en = 0; s_bg = 0;
        m_sx = 0; m_sy = 0; m_en = 0; m_bg = 0;
        pend_c = 0; pend_we = 0; p0 = 0; p1 = 0;
        @(negedge vga_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #45;
        chk("por_rgb", 32'(rgb), 32'd0);
        chk("por_fs", 32'(frame_start), 32'd0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        step(799, 524);
        chk_en = 1;

        // Unwritten background stays black, one frame_start per commit
        scan(95, 140, 48, 52);
        commit();
        lit("black", 10, 10, 10'd0, 24'h000000);

        wr(3, 24'h203040);
        wr(2, 24'h0);
        commit();
        lit("bg", 10, 10, 10'd0, 24'h203040);
        lit("blank_x", 645, 10, 10'd0, 24'h000000);
        lit("blank_y", 10, 490, 10'd0, 24'h000000);

        wr(0, 24'd100);
        wr(1, 24'd50);
        wr(2, 24'd1);
        commit();
`ifdef SPRITE_SCALE2X_EN
        lit("sc_s00", 100, 50, 10'd0, 24'hA00000);
        lit("sc_s11", 101, 51, 10'd0, 24'hA00000);
        lit("sc_s20", 102, 50, 10'd1, 24'hA00001);
        scan(90, 170, 45, 115);
`else
        lit("s00", 100, 50, 10'd0, 24'hA00000);
        lit("s_last", 131, 81, 10'd1023, 24'hA003FF);
        lit("right", 132, 81, 10'd0, 24'h203040);
        lit("key", 105, 50, 10'd5, 24'h203040);
        lit("n104", 104, 50, 10'd4, 24'hA00004);
        lit("n106", 106, 50, 10'd6, 24'hA00006);
        scan(90, 140, 45, 85);
`endif

        // Mid-frame position write must not move the sprite until the next commit
        step(50, 60, 1, 0, 24'd200);
        scan(90, 240, 60, 62);
`ifndef SPRITE_SCALE2X_EN
        lit("old_pos", 100, 70, 10'd640, 24'hA00280);
`endif
        commit(1, 0, 24'd300);
        scan(90, 240, 55, 56);
`ifndef SPRITE_SCALE2X_EN
        lit("new_pos", 200, 50, 10'd0, 24'hA00000);
        lit("old_gone", 100, 50, 10'd0, 24'h203040);
`endif
        commit();
        scan(290, 340, 50, 51);
`ifndef SPRITE_SCALE2X_EN
        lit("late_wr", 300, 50, 10'd0, 24'hA00000);
`endif

        // Right/bottom clipping without wrap, then fully off-screen
        wr(0, 24'd620);
        commit();
        scan(600, 639, 50, 52);
        scan(0, 15, 50, 52);
`ifndef SPRITE_SCALE2X_EN
        lit("clip_r", 639, 50, 10'd19, 24'hA00013);
        lit("clip_l", 5, 50, 10'd0, 24'h203040);
`endif
        wr(0, 24'd100);
        wr(1, 24'd470);
        commit();
        scan(98, 105, 468, 479);
        scan(98, 105, 0, 5);
        wr(0, 24'd1000);
        wr(1, 24'd50);
        commit();
        scan(0, 20, 50, 52);
        scan(620, 639, 50, 52);

        // Reset in the middle of a sprite loses every committed value
        wr(0, 24'd100);
        commit();
        scan(100, 115, 60, 60);
        mid_reset();
        step(110, 60);
        chk_en = 1;
        scan(95, 140, 55, 65);
        commit();
        lit("post_rst", 110, 60, 10'd0, 24'h000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
